mult_result_buffer: RTL and testbench

- Downstream stage of the FP32 single-precision multiplier.
- Captures each product word and its Exception/Overflow/Underflow flags into a small FIFO, and presents them to the consumer over a valid/ready handshake.
- Keeps sticky IEEE-style status flags and saturating per-flag event counters for software/debug readout.
- Decouples the combinational multiplier from a consumer that may stall.

---
 rtl/mult_result_buffer.sv | 194 +++++++++++++++++++
 tb/tb_mult_result_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_result_buffer.sv
// mult_result_buffer
// Output buffer for the FP32 multiplier. Products and their
// {exception, overflow, underflow} flags go into a small circular FIFO.
// The head entry is presented to the consumer over a valid/ready handshake.
// Sticky status flags and saturating per-flag event counters are kept
// for software/debug readout.
//
// Build option: define MULT_BUF_NAN_CANON_EN to store the canonical quiet
// NaN 32'h7FC0_0000 in place of in_result for every push with
// in_exception=1. Without it, in_result is stored verbatim.
//
// The head outputs (out_valid/out_result/out_flags) are registered. They
// are loaded from the next-state pointers each cycle, so a pushed entry
// appears one edge after it is accepted and never combinationally.

module mult_result_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_result,
    input  logic                         in_exception,
    input  logic                         in_overflow,
    input  logic                         in_underflow,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_result,
    output logic [2:0]                   out_flags,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [2:0]                   sticky_flags,
    input  logic                         clear_sticky,
    input  logic                         clear_stats,
    output logic [CNT_W-1:0]             exc_count,
    output logic [CNT_W-1:0]             ovf_count,
    output logic [CNT_W-1:0]             unf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Saturating event counter update; a clear still lets the same-cycle
    // increment land, so clear+increment yields 1.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             clr
    );
        logic [CNT_W-1:0] base;
        base = clr ? {CNT_W{1'b0}} : cnt;
        if (inc && (base != {CNT_W{1'b1}})) begin
            cnt_next = base + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_next = base;
        end
    endfunction

    logic [31:0]      mem_result_r [DEPTH];
    logic [2:0]       mem_flags_r  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] occ_r;
    logic             out_valid_r;
    logic [31:0]      out_result_r;
    logic [2:0]       out_flags_r;
    logic [2:0]       sticky_r;
    logic [CNT_W-1:0] exc_cnt_r;
    logic [CNT_W-1:0] ovf_cnt_r;
    logic [CNT_W-1:0] unf_cnt_r;

    logic             full_s;
    logic             push_s;
    logic             pop_s;
    logic [2:0]       in_flags_s;
    logic [31:0]      store_result_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [OCC_W-1:0] occ_nxt_s;
    logic [31:0]      head_result_nxt_s;
    logic [2:0]       head_flags_nxt_s;

    assign full_s     = (occ_r == OCC_W'(DEPTH));
    assign in_ready   = !full_s && !reset;
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid_r && out_ready;
    assign in_flags_s = {in_exception, in_overflow, in_underflow};

`ifdef MULT_BUF_NAN_CANON_EN
    assign store_result_s = in_exception ? 32'h7FC0_0000 : in_result;
`else
    assign store_result_s = in_result;
`endif

    // Next pointers and occupancy for this cycle's push/pop combination.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        occ_nxt_s    = occ_r;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + {{(OCC_W-1){1'b0}}, 1'b1};
            2'b01:   occ_nxt_s = occ_r - {{(OCC_W-1){1'b0}}, 1'b1};
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Head entry after this edge; the entry being written now is forwarded
    // into the output register when it becomes the new head.
    always_comb begin
        head_result_nxt_s = 32'h0000_0000;
        head_flags_nxt_s  = 3'b000;
        if (occ_nxt_s == {OCC_W{1'b0}}) begin
            head_result_nxt_s = 32'h0000_0000;
            head_flags_nxt_s  = 3'b000;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_result_nxt_s = store_result_s;
            head_flags_nxt_s  = in_flags_s;
        end else begin
            head_result_nxt_s = mem_result_r[rd_ptr_nxt_s];
            head_flags_nxt_s  = mem_flags_r[rd_ptr_nxt_s];
        end
    end

    // Storage array write; contents are not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_result_r[wr_ptr_r] <= store_result_s;
            mem_flags_r[wr_ptr_r]  <= in_flags_s;
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            occ_r        <= {OCC_W{1'b0}};
            out_valid_r  <= 1'b0;
            out_result_r <= 32'h0000_0000;
            out_flags_r  <= 3'b000;
        end else begin
            wr_ptr_r     <= wr_ptr_nxt_s;
            rd_ptr_r     <= rd_ptr_nxt_s;
            occ_r        <= occ_nxt_s;
            out_valid_r  <= (occ_nxt_s != {OCC_W{1'b0}});
            out_result_r <= head_result_nxt_s;
            out_flags_r  <= head_flags_nxt_s;
        end
    end

    // Sticky flags: clear first, then OR in the flags of an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_r <= 3'b000;
        end else begin
            sticky_r <= (clear_sticky ? 3'b000 : sticky_r) |
                        (push_s ? in_flags_s : 3'b000);
        end
    end

    // Per-flag saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_cnt_r <= {CNT_W{1'b0}};
            ovf_cnt_r <= {CNT_W{1'b0}};
            unf_cnt_r <= {CNT_W{1'b0}};
        end else begin
            exc_cnt_r <= cnt_next(exc_cnt_r, push_s && in_exception, clear_stats);
            ovf_cnt_r <= cnt_next(ovf_cnt_r, push_s && in_overflow,  clear_stats);
            unf_cnt_r <= cnt_next(unf_cnt_r, push_s && in_underflow, clear_stats);
        end
    end

    assign out_valid    = out_valid_r;
    assign out_result   = out_result_r;
    assign out_flags    = out_flags_r;
    assign occupancy    = occ_r;
    assign sticky_flags = sticky_r;
    assign exc_count    = exc_cnt_r;
    assign ovf_count    = ovf_cnt_r;
    assign unf_count    = unf_cnt_r;

endmodule

// File: tb/tb_mult_result_buffer.sv
// Directed testbench for mult_result_buffer (DEPTH=4, CNT_W=2).
module tb_mult_result_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_exception;
    logic        in_overflow;
    logic        in_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [2:0]  occupancy;
    logic [2:0]  sticky_flags;
    logic        clear_sticky;
    logic        clear_stats;
    logic [1:0]  exc_count;
    logic [1:0]  ovf_count;
    logic [1:0]  unf_count;

    int n_checks;
    int n_fail;

    logic [31:0] drain_words [4];
    logic [31:0] nan_expected;

    mult_result_buffer #(.DEPTH(4), .CNT_W(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_exception (in_exception),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .occupancy    (occupancy),
        .sticky_flags (sticky_flags),
        .clear_sticky (clear_sticky),
        .clear_stats  (clear_stats),
        .exc_count    (exc_count),
        .ovf_count    (ovf_count),
        .unf_count    (unf_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] f);
        in_valid     = v;
        in_result    = r;
        in_exception = f[2];
        in_overflow  = f[1];
        in_underflow = f[0];
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drain_words[0] = 32'h3F80_0000;
        drain_words[1] = 32'h4000_0000;
        drain_words[2] = 32'h4040_0000;
        drain_words[3] = 32'h4080_0000;
`ifdef MULT_BUF_NAN_CANON_EN
        nan_expected = 32'h7FC0_0000;
`else
        nan_expected = 32'h0000_0000;
`endif
        reset        = 1'b1;
        out_ready    = 1'b0;
        clear_sticky = 1'b0;
        clear_stats  = 1'b0;
        drive(1'b0, 32'h0000_0000, 3'b000);
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_occ", {29'd0, occupancy}, 32'd0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("idle_sticky", {29'd0, sticky_flags}, 32'd0);
        check("idle_exc_cnt", {30'd0, exc_count}, 32'd0);
        check("idle_out_result", out_result, 32'd0);

        // Single push, no same-cycle pass-through, visible after the edge.
        drive(1'b1, 32'h40C0_0000, 3'b000);
        check("no_passthru", {31'd0, out_valid}, 32'd0);
        step();
        drive(1'b0, 32'h0000_0000, 3'b000);
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_result", out_result, 32'h40C0_0000);
        check("t1_flags", {29'd0, out_flags}, 32'd0);
        check("t1_occ", {29'd0, occupancy}, 32'd1);
        check("t1_in_ready", {31'd0, in_ready}, 32'd1);
        check("t1_hold", out_result, 32'h40C0_0000);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t1_empty_valid", {31'd0, out_valid}, 32'd0);
        check("t1_empty_result", out_result, 32'd0);

        // Fill to full, refuse a fifth entry, drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, drain_words[i], 3'b000);
            step();
        end
        check("full_occ", {29'd0, occupancy}, 32'd4);
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        check("full_head", out_result, 32'h3F80_0000);
        drive(1'b1, 32'h40A0_0000, 3'b000);
        out_ready = 1'b1;
        #1;
        check("full_in_ready_pop", {31'd0, in_ready}, 32'd0);
        for (int i = 1; i < 5; i++) begin
            step();
            drive(1'b0, 32'h0000_0000, 3'b000);
            if (i < 4) begin
                check("drain_word", out_result, drain_words[i]);
                check("drain_occ", {29'd0, occupancy}, 32'(4 - i));
            end else begin
                check("drain_valid", {31'd0, out_valid}, 32'd0);
                check("drain_result", out_result, 32'd0);
                check("drain_occ0", {29'd0, occupancy}, 32'd0);
            end
        end

        // Steady stream across pointer wrap.
        out_ready = 1'b0;
        drive(1'b1, 32'h1000_0000, 3'b000);
        step();
        out_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 32'h1000_0000 + 32'(i), 3'b000);
            step();
            check("stream_word", out_result, 32'h1000_0000 + 32'(i));
            check("stream_occ", {29'd0, occupancy}, 32'd1);
        end
        drive(1'b0, 32'h0000_0000, 3'b000);
        step();
        check("stream_end_valid", {31'd0, out_valid}, 32'd0);

        // Sticky flags and counters.
        drive(1'b1, 32'h7F80_0000, 3'b010);
        step();
        check("ovf_flags_head", {29'd0, out_flags}, 32'd2);
        drive(1'b1, 32'h0000_0000, 3'b001);
        step();
        drive(1'b0, 32'h0000_0000, 3'b000);
        check("sticky_011", {29'd0, sticky_flags}, 32'd3);
        check("ovf_cnt_1", {30'd0, ovf_count}, 32'd1);
        check("unf_cnt_1", {30'd0, unf_count}, 32'd1);
        clear_sticky = 1'b1;
        drive(1'b1, 32'h7F80_0000, 3'b010);
        step();
        clear_sticky = 1'b0;
        drive(1'b0, 32'h0000_0000, 3'b000);
        check("sticky_set_wins", {29'd0, sticky_flags}, 32'd2);
        check("ovf_cnt_2", {30'd0, ovf_count}, 32'd2);
        step();
        check("pre_nan_empty", {31'd0, out_valid}, 32'd0);

        // Exception entry storage, counter saturation, clear+increment.
        out_ready = 1'b0;
        drive(1'b1, 32'h0000_0000, 3'b100);
        step();
        check("nan_result", out_result, nan_expected);
        check("nan_flags", {29'd0, out_flags}, 32'd4);
        check("exc_cnt_1", {30'd0, exc_count}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h8000_0000 + 32'(i), 3'b100);
            step();
        end
        check("exc_cnt_sat", {30'd0, exc_count}, 32'd3);
        check("sticky_exc", {29'd0, sticky_flags}, 32'd6);
        clear_stats = 1'b1;
        drive(1'b1, 32'h0000_0000, 3'b100);
        step();
        clear_stats = 1'b0;
        check("exc_clr_inc", {30'd0, exc_count}, 32'd1);
        check("ovf_clr", {30'd0, ovf_count}, 32'd0);
        check("unf_clr", {30'd0, unf_count}, 32'd0);

        // Reset with three stored entries, observed before the next edge.
        out_ready = 1'b0;
        drive(1'b1, 32'h1234_5678, 3'b000);
        step();
        step();
        drive(1'b0, 32'h0000_0000, 3'b000);
        check("pre_rst_occ", {29'd0, occupancy}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_occ", {29'd0, occupancy}, 32'd0);
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("async_rst_sticky", {29'd0, sticky_flags}, 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_rst_occ", {29'd0, occupancy}, 32'd0);
        check("post_rst_result", out_result, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
